store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 Parameter ADDR_LIMIT, default 65535, highest valid word address of data memory.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  request from pipeline is valid this cycle.
REQ-006 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-007 req_is_store  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  word address.
REQ-009 req_wdata  in  32  store data.
REQ-010 rsp_valid  out  1  load result valid.
REQ-011 rsp_rdata  out  32  load result.
REQ-012 rsp_err  out  1  pulses with an accepted request whose address exceeds ADDR_LIMIT.
REQ-013 mem_busy  in  1  inhibits draining to data memory this cycle.
REQ-014 mem_read_address  out  32  to data memory read port.
REQ-015 mem_data_out  in  32  combinational read data from data memory.
REQ-016 mem_write_address / mem_data_in  out  32 each  to data memory write port.
REQ-017 mem_write_enable  out  1  to data memory write enable.
REQ-018 empty  out  1  no stores pending.

Function
REQ-019 Block SHALL hold up to DEPTH stores in a circular FIFO (head/tail pointers, count 0..DEPTH).
REQ-020 req_ready SHALL be !full for stores and 1 for loads; a simultaneous pop does not raise req_ready.
REQ-021 Accepted store with addr <= ADDR_LIMIT SHALL be enqueued at tail on that edge.
REQ-022 Accepted store with addr > ADDR_LIMIT SHALL not be enqueued; rsp_err = 1 next cycle; no rsp_valid.
REQ-023 mem_write_enable SHALL equal !empty && !mem_busy, combinationally; address and data from head entry.
REQ-024 When mem_write_enable = 1 the head SHALL pop on that edge; push and pop in the same cycle leave count unchanged.
REQ-025 mem_read_address SHALL equal req_addr combinationally.
REQ-026 Accepted load SHALL produce rsp_valid = 1 exactly one cycle later (latency 1, registered), one pulse per load.
REQ-027 Load data SHALL be the youngest buffered entry with matching address (head being popped the same cycle included), else mem_data_out, captured on the accept edge.
REQ-028 Load with addr > ADDR_LIMIT SHALL return rsp_rdata = 0 with rsp_valid = 1 and rsp_err = 1.
REQ-029 rsp_rdata SHALL hold its value while rsp_valid = 0.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-031 On rst: head = tail = count = 0, empty = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, all entry valid bits 0.
REQ-032 rst mid-operation SHALL discard pending stores without writing them; mem_write_enable = 0 the cycle rst is high.
REQ-033 Requests presented while rst is high SHALL be ignored (req_ready = 0).

Structure
REQ-034 Shared package SHALL hold the entry record (addr 32, data 32, valid 1), default DEPTH and ADDR_LIMIT constants.
REQ-035 One sub-module, sb_match, SHALL perform the youngest-match address search over the entry array and return hit and data.

Verification
REQ-036 Reset, 5 stores (addr 2..6, data 10..14) with mem_busy = 1 -> 4 accepted, 5th stalls (req_ready = 0), empty = 0.
REQ-037 Release mem_busy -> writes addr 2,3,4,5 in order on 4 consecutive cycles, then addr 6; empty = 1 after final pop.
REQ-038 mem_busy = 1, store (7, 99) then (7, 42), load 7 -> rsp_valid next cycle, rsp_rdata = 42.
REQ-039 Empty buffer, memory word 9 = 1, load 9 -> rsp_rdata = 1 one cycle later.
REQ-040 Store to 70000 -> not enqueued, rsp_err pulses; load 70000 -> rsp_rdata = 0, rsp_err = 1.
REQ-041 3 stores queued, assert rst one cycle -> no mem_write_enable, empty = 1, rsp_valid = 0 afterwards.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer slice.
// Entry record plus default depth and memory limit.
package store_buffer_pkg;

    localparam int          SB_DEPTH      = 4;
    localparam logic [31:0] SB_ADDR_LIMIT = 32'd65535;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        valid;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the store buffer entries.
// Walks oldest to youngest so later hits override earlier ones.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [31:0]       addr,
    output logic              hit,
    output logic [31:0]       hit_data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (entries[idx].valid && entries[idx].addr == addr) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer draining to data memory, with load forwarding.
// Loads respond one cycle after acceptance; out-of-range requests flag rsp_err.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int          DEPTH      = SB_DEPTH,
    parameter logic [31:0] ADDR_LIMIT = SB_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        mem_busy,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_data_out,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write_enable,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          full;
    logic          accept;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          load;
    logic          hit;
    logic [31:0]   hit_data;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_range = (req_addr <= ADDR_LIMIT);

    // A pop in the same cycle never frees a slot for the incoming store.
    assign req_ready = !rst && (req_is_store ? !full : 1'b1);
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_is_store && in_range;
    assign load      = accept && !req_is_store;

    assign mem_write_enable  = !rst && !empty && !mem_busy;
    assign pop               = mem_write_enable;
    assign mem_write_address = entries[head].addr;
    assign mem_data_in       = entries[head].data;
    assign mem_read_address  = req_addr;

    sb_match #(
        .DEPTH    (DEPTH)
    ) u_match (
        .entries  (entries),
        .head     (head),
        .addr     (req_addr),
        .hit      (hit),
        .hit_data (hit_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{addr: req_addr, data: req_wdata, valid: 1'b1};
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            rsp_valid <= load;
            rsp_err   <= accept && !in_range;
            if (load) begin
                rsp_rdata <= !in_range ? '0 : (hit ? hit_data : mem_data_out);
            end
        end
    end

endmodule
